// File: rtl/instr_prefetch_queue_pkg.sv
// Shared fetch-stage types and constants for the instruction prefetch queue.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int INSTR_W   = 32;
    localparam int PC_STRIDE = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Memory fetch bus plus IF/ID delivery handshake seen by the prefetch queue.
interface instr_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc_plus4;
    logic              instr_ready;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, pc_plus4,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, pc_plus4,
        output mem_ack, mem_rdata, instr_ready
    );

endinterface

// File: rtl/instr_prefetch_queue_fifo.sv
// Small register-based FIFO of {instruction, pc+4} pairs with push/pop/clear.
module prefetch_fifo
    import cpu_pipe_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = INSTR_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [ADDR_W-1:0]        wpc_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    output logic                     valid_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [ADDR_W-1:0]        rpc_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;
    logic [DATA_W-1:0] instr_arr [DEPTH];
    logic [ADDR_W-1:0] pc_arr    [DEPTH];

    assign do_push = push_i & ~clear_i;
    assign do_pop  = pop_i & ~clear_i & (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slots reset to zero so the head outputs read 0 straight out of reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [DATA_W-1:0] instr_q;
            logic [ADDR_W-1:0] pc_q;

            always_ff @(posedge clk_i or negedge rst_n) begin
                if (!rst_n) begin
                    instr_q <= DATA_W'(NOP_INSTR);
                    pc_q    <= '0;
                end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                    instr_q <= wdata_i;
                    pc_q    <= wpc_i;
                end
            end

            assign instr_arr[gi] = instr_q;
            assign pc_arr[gi]    = pc_q;
        end
    endgenerate

    assign valid_o = (count_q != '0);
    assign rdata_o = instr_arr[rd_ptr_q];
    assign rpc_o   = pc_arr[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch front-end: single-outstanding sequential fetch FSM feeding a prefetch FIFO.
// Optional QUEUE_BYPASS_EN forwards an ack straight to the IF/ID side when the queue is empty.
module instr_prefetch_queue
    import cpu_pipe_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_n,
    instr_prefetch_queue_if.master bus,
    input  logic                   flush_i,
    input  logic [ADDR_W-1:0]      flush_pc_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int                CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(PC_STRIDE);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] flush_target;
    logic              ack_take;
    logic              bypass_take;
    logic              fifo_push, fifo_pop, fifo_valid;
    logic [DATA_W-1:0] fifo_instr;
    logic [ADDR_W-1:0] fifo_pc;
    logic [CNT_W-1:0]  fifo_count;

    assign flush_target = flush_pc_i & ~ADDR_W'(3);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        ack_take   = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    fetch_pc_d = flush_target;
                end else if (fifo_count < FULL_CNT) begin
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            WAIT: begin
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (flush_i) begin
                        fetch_pc_d = flush_target;
                    end else begin
                        ack_take   = 1'b1;
                        fetch_pc_d = fetch_pc_q + STRIDE;
                    end
                end else if (flush_i) begin
                    state_d    = DROP;
                    fetch_pc_d = flush_target;
                end
            end
            DROP: begin
                // The stale request must still complete; only the redirect target moves.
                if (flush_i) fetch_pc_d = flush_target;
                if (bus.mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;

`ifdef QUEUE_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit      = ack_take & (fifo_count == '0);
    assign bus.instr_valid = fifo_valid | bypass_hit;
    assign bus.instr       = bypass_hit ? bus.mem_rdata : fifo_instr;
    assign bus.pc_plus4    = bypass_hit ? (mem_addr_q + STRIDE) : fifo_pc;
    assign bypass_take     = bypass_hit & bus.instr_ready;
`else
    assign bus.instr_valid = fifo_valid;
    assign bus.instr       = fifo_instr;
    assign bus.pc_plus4    = fifo_pc;
    assign bypass_take     = 1'b0;
`endif

    // Flush wins over both ends of the queue.
    assign fifo_push = ack_take & ~bypass_take;
    assign fifo_pop  = fifo_valid & bus.instr_ready & ~flush_i;

    prefetch_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (bus.mem_rdata),
        .wpc_i   (mem_addr_q + STRIDE),
        .pop_i   (fifo_pop),
        .clear_i (flush_i),
        .valid_o (fifo_valid),
        .rdata_o (fifo_instr),
        .rpc_o   (fifo_pc),
        .count_o (fifo_count)
    );

    assign count_o = fifo_count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed self-checking bench for instr_prefetch_queue (DEPTH=4, RESET_PC=0).
module tb_instr_prefetch_queue;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush_i = 1'b0;
    logic [AW-1:0] flush_pc_i = '0;
    logic [2:0]    count_o;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_lat = 1;
    int wait_cnt = 0;

    instr_prefetch_queue_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_prefetch_queue #(
        .DEPTH    (4),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC ('0)
    ) dut (
        .clk_i      (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush_i    (flush_i),
        .flush_pc_i (flush_pc_i),
        .count_o    (count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC000_0000 | a;
    endfunction

    // Memory: acks once req has been seen for more than ack_lat cycles.
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                wait_cnt    = 0;
            end else if (bus.mem_req) begin
                wait_cnt++;
                if (wait_cnt > ack_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic probe(input int which, input int n);
        case (which)
            0:       return bus.mem_req;
            1:       return bus.mem_ack;
            2:       return bus.instr_valid;
            default: return (count_o == n[2:0]);
        endcase
    endfunction

    task automatic wait_for(input string tag, input int which, input int n);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (probe(which, n)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        assert (hit === 1'b1) else begin
            n_bad++;
            $error("FAIL %s: timed out, observed 0 expected 1", tag);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        flush_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req",   64'(bus.mem_req),     64'h0);
        chk("rst_addr",  64'(bus.mem_addr),    64'h0);
        chk("rst_valid", 64'(bus.instr_valid), 64'h0);
        chk("rst_instr", 64'(bus.instr),       64'h0);
        chk("rst_pc4",   64'(bus.pc_plus4),    64'h0);
        chk("rst_count", 64'(count_o),         64'h0);
        rst_n = 1'b1;

        // 1: sequential fetch with 1-cycle ack latency, pipeline always ready
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_for("t1_ack", 1, 0);
            chk("t1_addr", 64'(bus.mem_addr), 64'(4 * k));
            wait_for("t1_valid", 2, 0);
            chk("t1_instr", 64'(bus.instr),    64'(mem_word(32'(4 * k))));
            chk("t1_pc4",   64'(bus.pc_plus4), 64'(4 * k + 4));
            @(negedge clk);
        end
        chk("t1_count", 64'(count_o), 64'h0);
        $display("t1 sequential fetch done");

        // 2: stall fills the queue, then drain in order
        ack_lat = 1;
        bus.instr_ready = 1'b0;
        do_reset();
        wait_for("t2_full", 3, 4);
        chk("t2_count", 64'(count_o), 64'h4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_req_full", 64'(bus.mem_req), 64'h0);
        end
        chk("t2_count_hold", 64'(count_o), 64'h4);
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2_valid", 64'(bus.instr_valid), 64'h1);
            chk("t2_instr", 64'(bus.instr),       64'(mem_word(32'(4 * k))));
            chk("t2_pc4",   64'(bus.pc_plus4),    64'(4 * k + 4));
            @(negedge clk);
        end
        wait_for("t2_resume", 2, 0);
        chk("t2_resume_instr", 64'(bus.instr),    64'(mem_word(32'h10)));
        chk("t2_resume_pc4",   64'(bus.pc_plus4), 64'h14);
        $display("t2 stall and drain done");

        // 3: flush while waiting, ack arrives 3 cycles later and is dropped
        ack_lat = 3;
        bus.instr_ready = 1'b1;
        do_reset();
        wait_for("t3_req", 0, 0);
        chk("t3_addr0", 64'(bus.mem_addr), 64'h0);
        flush_i    = 1'b1;
        flush_pc_i = 32'h40;
        @(negedge clk);
        flush_i = 1'b0;
        chk("t3_drop_req",  64'(bus.mem_req),  64'h1);
        chk("t3_drop_addr", 64'(bus.mem_addr), 64'h0);
        wait_for("t3_ack", 1, 0);
        chk("t3_ack_addr",  64'(bus.mem_addr),    64'h0);
        chk("t3_ack_valid", 64'(bus.instr_valid), 64'h0);
        @(negedge clk);
        chk("t3_count", 64'(count_o),         64'h0);
        chk("t3_valid", 64'(bus.instr_valid), 64'h0);
        chk("t3_req_off", 64'(bus.mem_req),   64'h0);
        wait_for("t3_req2", 0, 0);
        chk("t3_addr_redirect", 64'(bus.mem_addr), 64'h40);
        wait_for("t3_valid2", 2, 0);
        chk("t3_pc4",   64'(bus.pc_plus4), 64'h44);
        chk("t3_instr", 64'(bus.instr),    64'(mem_word(32'h40)));
        $display("t3 flush in WAIT done");

        // 4: flush coincides with ack and pop; target low bits cleared
        ack_lat = 1;
        bus.instr_ready = 1'b0;
        do_reset();
        wait_for("t4_one", 3, 1);
        wait_for("t4_ack", 1, 0);
        chk("t4_ack_addr", 64'(bus.mem_addr),    64'h4);
        chk("t4_pre_valid", 64'(bus.instr_valid), 64'h1);
        chk("t4_pre_count", 64'(count_o),        64'h1);
        bus.instr_ready = 1'b1;
        flush_i    = 1'b1;
        flush_pc_i = 32'h103;
        @(negedge clk);
        flush_i = 1'b0;
        chk("t4_count", 64'(count_o),         64'h0);
        chk("t4_valid", 64'(bus.instr_valid), 64'h0);
        wait_for("t4_req", 0, 0);
        chk("t4_addr", 64'(bus.mem_addr), 64'h100);
        $display("t4 flush with ack and pop done");

        // 5: async reset mid-WAIT with two entries queued
        ack_lat = 1;
        bus.instr_ready = 1'b0;
        do_reset();
        wait_for("t5_two", 3, 2);
        wait_for("t5_req", 0, 0);
        chk("t5_pre_count", 64'(count_o),      64'h2);
        chk("t5_pre_addr",  64'(bus.mem_addr), 64'h8);
        rst_n = 1'b0;
        #1;
        chk("t5_req",   64'(bus.mem_req),     64'h0);
        chk("t5_addr",  64'(bus.mem_addr),    64'h0);
        chk("t5_valid", 64'(bus.instr_valid), 64'h0);
        chk("t5_instr", 64'(bus.instr),       64'h0);
        chk("t5_pc4",   64'(bus.pc_plus4),    64'h0);
        chk("t5_count", 64'(count_o),         64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for("t5_req2", 0, 0);
        chk("t5_addr_restart", 64'(bus.mem_addr), 64'h0);
        $display("t5 reset mid-WAIT done");

        // 6: empty queue, ack with ready high
        ack_lat = 1;
        bus.instr_ready = 1'b1;
        do_reset();
        wait_for("t6_ack", 1, 0);
`ifdef QUEUE_BYPASS_EN
        chk("t6_valid_ack", 64'(bus.instr_valid), 64'h1);
        chk("t6_instr_ack", 64'(bus.instr),       64'(mem_word(32'h0)));
        chk("t6_pc4_ack",   64'(bus.pc_plus4),    64'h4);
        chk("t6_count_ack", 64'(count_o),         64'h0);
        @(negedge clk);
        chk("t6_count_next", 64'(count_o),         64'h0);
        chk("t6_valid_next", 64'(bus.instr_valid), 64'h0);
`else
        chk("t6_valid_ack", 64'(bus.instr_valid), 64'h0);
        chk("t6_count_ack", 64'(count_o),         64'h0);
        @(negedge clk);
        chk("t6_valid_next", 64'(bus.instr_valid), 64'h1);
        chk("t6_pc4_next",   64'(bus.pc_plus4),    64'h4);
        chk("t6_count_next", 64'(count_o),         64'h1);
`endif
        $display("t6 ack-to-valid latency done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
